sobel_line_sched: RTL and testbench

//  Sequences two external line FIFOs (fifo1, fifo2) to form a 3-row pixel column for the Sobel window.

---
 rtl/sobel_pkg.sv | 20 ++
 rtl/sobel_pix_cnt.sv | 64 ++++++
 rtl/sobel_line_sched.sv | 123 ++++++++++++
 tb/tb_sobel_line_sched.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// rtl/sobel_pkg.sv - shared types and constants for the Sobel line scheduler
package sobel_pkg;

   // One state per row band of the frame
   typedef enum logic [1:0] {
      FILL1 = 2'd0,
      FILL2 = 2'd1,
      RUN   = 2'd2,
      LAST  = 2'd3
   } sobel_state_t;

   // pi_flag -> win_flag latency in cycles
   localparam int TAP_DEPTH = 2;

   // Counter width for a range of n values, never narrower than one bit
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/sobel_pix_cnt.sv
// rtl/sobel_pix_cnt.sv - column/row position counter for the incoming pixel stream
module sobel_pix_cnt
   import sobel_pkg::*;
#(
   parameter int COLS = 50,
   parameter int ROWS = 50,
   parameter int CW   = cnt_width(COLS),
   parameter int RW   = cnt_width(ROWS)
) (
   input  logic          sclk,
   input  logic          rst,
   input  logic          adv_i,
   output logic          eol_o,
   output logic          eof_o,
   output logic          pre_last_o,
   output logic [CW-1:0] col_cnt_o,
   output logic [RW-1:0] row_cnt_o
);

   // col_q/row_q give the position of the pixel about to be accepted;
   // last_*_q report the position of the pixel most recently accepted.
   logic [CW-1:0] col_q, col_d, last_col_q, last_col_d;
   logic [RW-1:0] row_q, row_d, last_row_q, last_row_d;

   assign eol_o      = (col_q == CW'(COLS - 1));
   assign eof_o      = eol_o && (row_q == RW'(ROWS - 1));
   assign pre_last_o = (row_q == RW'(ROWS - 2));
   assign col_cnt_o  = last_col_q;
   assign row_cnt_o  = last_row_q;

   // Advance position on each accepted pixel, wrapping column then row
   always_comb begin
      col_d      = col_q;
      row_d      = row_q;
      last_col_d = last_col_q;
      last_row_d = last_row_q;
      if (adv_i) begin
         last_col_d = col_q;
         last_row_d = row_q;
         if (eol_o) begin
            col_d = '0;
            row_d = eof_o ? '0 : row_q + RW'(1);
         end else begin
            col_d = col_q + CW'(1);
         end
      end
   end

   // Position registers
   always_ff @(posedge sclk or posedge rst) begin
      if (rst) begin
         col_q      <= '0;
         row_q      <= '0;
         last_col_q <= '0;
         last_row_q <= '0;
      end else begin
         col_q      <= col_d;
         row_q      <= row_d;
         last_col_q <= last_col_d;
         last_row_q <= last_row_d;
      end
   end

endmodule

// File: rtl/sobel_line_sched.sv
// rtl/sobel_line_sched.sv - routes pixels through two line FIFOs and emits a 3-row tap column
module sobel_line_sched
   import sobel_pkg::*;
#(
   parameter int  COLS = 50,
   parameter int  ROWS = 50,
   parameter int  DW   = 8,
   localparam int CW   = cnt_width(COLS),
   localparam int RW   = cnt_width(ROWS)
) (
   input  logic          sclk,
   input  logic          rst,
   input  logic          pi_flag,
   input  logic [DW-1:0] pi_data,
   output logic          fifo1_wr_en,
   output logic [DW-1:0] fifo1_wr_data,
   output logic          fifo1_rd_en,
   input  logic [DW-1:0] fifo1_rd_data,
   output logic          fifo2_wr_en,
   output logic [DW-1:0] fifo2_wr_data,
   output logic          fifo2_rd_en,
   input  logic [DW-1:0] fifo2_rd_data,
   output logic          win_flag,
   output logic [DW-1:0] tap_top,
   output logic [DW-1:0] tap_mid,
   output logic [DW-1:0] tap_bot,
   output logic [CW-1:0] col_cnt,
   output logic [RW-1:0] row_cnt,
   output logic          frame_done
);

   sobel_state_t         state_q, state_d;
   logic                 eol, eof, pre_last, rd_state;
   logic [DW-1:0]        d1_q;
   logic                 wr1_q, wr2_q, wr1_shift_q;
   logic [TAP_DEPTH-1:0] win_sr_q, eof_sr_q;
   logic [DW-1:0]        top_q, mid_q, bot_q;

   sobel_pix_cnt #(
      .COLS (COLS),
      .ROWS (ROWS),
      .CW   (CW),
      .RW   (RW)
   ) u_pix_cnt (
      .sclk       (sclk),
      .rst        (rst),
      .adv_i      (pi_flag),
      .eol_o      (eol),
      .eof_o      (eof),
      .pre_last_o (pre_last),
      .col_cnt_o  (col_cnt),
      .row_cnt_o  (row_cnt)
   );

   // Row-band sequencing; the change takes effect from the next pixel on
   always_comb begin
      state_d = state_q;
      if (pi_flag && eol) begin
         case (state_q)
            FILL1:   state_d = FILL2;
            FILL2:   state_d = pre_last ? LAST : RUN;
            RUN:     state_d = pre_last ? LAST : RUN;
            default: state_d = FILL1;
         endcase
      end
   end

   // State register
   always_ff @(posedge sclk or posedge rst) begin
      if (rst) begin
         state_q <= FILL1;
      end else begin
         state_q <= state_d;
      end
   end

   // Both FIFOs are read together once two lines are buffered
   assign rd_state    = (state_q == RUN) || (state_q == LAST);
   assign fifo1_rd_en = pi_flag & rd_state;
   assign fifo2_rd_en = pi_flag & rd_state;

   // In RUN the middle line ages into fifo1 straight from fifo2's read port
   assign fifo1_wr_en   = wr1_q;
   assign fifo1_wr_data = wr1_shift_q ? fifo2_rd_data : d1_q;
   assign fifo2_wr_en   = wr2_q;
   assign fifo2_wr_data = d1_q;

   assign win_flag   = win_sr_q[TAP_DEPTH-1];
   assign frame_done = eof_sr_q[TAP_DEPTH-1];
   assign tap_top    = top_q;
   assign tap_mid    = mid_q;
   assign tap_bot    = bot_q;

   // Pixel delay, write strobes and the tap pipeline; taps hold when idle
   always_ff @(posedge sclk or posedge rst) begin
      if (rst) begin
         d1_q        <= '0;
         wr1_q       <= 1'b0;
         wr2_q       <= 1'b0;
         wr1_shift_q <= 1'b0;
         win_sr_q    <= '0;
         eof_sr_q    <= '0;
         top_q       <= '0;
         mid_q       <= '0;
         bot_q       <= '0;
      end else begin
         wr1_q    <= pi_flag & ((state_q == FILL1) || (state_q == RUN));
         wr2_q    <= pi_flag & ((state_q == FILL2) || (state_q == RUN));
         win_sr_q <= {win_sr_q[TAP_DEPTH-2:0], pi_flag & rd_state};
         eof_sr_q <= {eof_sr_q[TAP_DEPTH-2:0], pi_flag & rd_state & eof};
         if (pi_flag) begin
            d1_q        <= pi_data;
            wr1_shift_q <= (state_q == RUN);
         end
         if (win_sr_q[0]) begin
            top_q <= fifo1_rd_data;
            mid_q <= fifo2_rd_data;
            bot_q <= d1_q;
         end
      end
   end

endmodule

// File: tb/tb_sobel_line_sched.sv
// tb/tb_sobel_line_sched.sv - scoreboard bench for sobel_line_sched at 4x3 and 4x5 frames
module tb_sobel_line_sched;

   typedef struct packed {
      logic [7:0]  t;
      logic [7:0]  m;
      logic [7:0]  b;
      logic        fd;
      logic [31:0] cyc;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int compared = 0;
   int mismatched = 0;
   int cyc = 0;
   bit done = 1'b0;

   // DUT A: 4x3
   logic       rst_a, flag_a;
   logic [7:0] data_a;
   logic       f1we_a, f1re_a, f2we_a, f2re_a;
   logic [7:0] f1wd_a, f1rd_a, f2wd_a, f2rd_a;
   logic       win_a, fd_a;
   logic [7:0] top_a, mid_a, bot_a;
   logic [1:0] col_a, row_a;
   // DUT B: 4x5
   logic       rst_b, flag_b;
   logic [7:0] data_b;
   logic       f1we_b, f1re_b, f2we_b, f2re_b;
   logic [7:0] f1wd_b, f1rd_b, f2wd_b, f2rd_b;
   logic       win_b, fd_b;
   logic [7:0] top_b, mid_b, bot_b;
   logic [1:0] col_b;
   logic [2:0] row_b;

   logic [7:0] f1_a[$], f2_a[$], f1_b[$], f2_b[$];
   logic [7:0] wlog1_a[$], wlog2_a[$];
   exp_t       exp_a[$], exp_b[$];
   exp_t       mon_e;

   // Reference model: pixel store and position per DUT
   logic [7:0] mem [2][5][4];
   int         mr[2], mc[2];

   sobel_line_sched #(.COLS(4), .ROWS(3), .DW(8)) u_a (
      .sclk(clk), .rst(rst_a), .pi_flag(flag_a), .pi_data(data_a),
      .fifo1_wr_en(f1we_a), .fifo1_wr_data(f1wd_a), .fifo1_rd_en(f1re_a), .fifo1_rd_data(f1rd_a),
      .fifo2_wr_en(f2we_a), .fifo2_wr_data(f2wd_a), .fifo2_rd_en(f2re_a), .fifo2_rd_data(f2rd_a),
      .win_flag(win_a), .tap_top(top_a), .tap_mid(mid_a), .tap_bot(bot_a),
      .col_cnt(col_a), .row_cnt(row_a), .frame_done(fd_a));

   sobel_line_sched #(.COLS(4), .ROWS(5), .DW(8)) u_b (
      .sclk(clk), .rst(rst_b), .pi_flag(flag_b), .pi_data(data_b),
      .fifo1_wr_en(f1we_b), .fifo1_wr_data(f1wd_b), .fifo1_rd_en(f1re_b), .fifo1_rd_data(f1rd_b),
      .fifo2_wr_en(f2we_b), .fifo2_wr_data(f2wd_b), .fifo2_rd_en(f2re_b), .fifo2_rd_data(f2rd_b),
      .win_flag(win_b), .tap_top(top_b), .tap_mid(mid_b), .tap_bot(bot_b),
      .col_cnt(col_b), .row_cnt(row_b), .frame_done(fd_b));

   task automatic model_reset(input int sel);
      mr[sel] = 0;
      mc[sel] = 0;
   endtask

   // Drive one pixel (called just after a rising edge), push its expected window, then idle gap cycles
   task automatic send(input int sel, input logic [7:0] v, input int gap);
      int   r, c, rows;
      exp_t e;
      r = mr[sel];
      c = mc[sel];
      rows = (sel == 0) ? 3 : 5;
      mem[sel][r][c] = v;
      if (r >= 2) begin
         e.t = mem[sel][r-2][c];
         e.m = mem[sel][r-1][c];
         e.b = v;
         e.fd = (r == rows - 1) && (c == 3);
         e.cyc = 32'(cyc + 2);
         if (sel == 0) exp_a.push_back(e);
         else exp_b.push_back(e);
      end
      if (c == 3) begin
         mc[sel] = 0;
         mr[sel] = (r == rows - 1) ? 0 : r + 1;
      end else begin
         mc[sel] = c + 1;
      end
      if (sel == 0) begin flag_a = 1'b1; data_a = v; end
      else begin flag_b = 1'b1; data_b = v; end
      @(posedge clk); #1;
      flag_a = 1'b0;
      flag_b = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
   endtask

   task automatic drain(input int sel, input string name);
      repeat (5) @(posedge clk);
      #1;
      compared++;
      if (sel == 0) begin
         if (exp_a.size() != 0 || f1_a.size() != 0 || f2_a.size() != 0) begin
            mismatched++;
            $display("FAIL %s_drain_a: got pending=%0d fifo1=%0d fifo2=%0d, want 0/0/0", name, exp_a.size(), f1_a.size(), f2_a.size());
         end
      end else begin
         if (exp_b.size() != 0 || f1_b.size() != 0 || f2_b.size() != 0) begin
            mismatched++;
            $display("FAIL %s_drain_b: got pending=%0d fifo1=%0d fifo2=%0d, want 0/0/0", name, exp_b.size(), f1_b.size(), f2_b.size());
         end
      end
   endtask

   task automatic test_reset();
      rst_a = 1'b1; rst_b = 1'b1;
      flag_a = 1'b0; flag_b = 1'b0; data_a = 8'h5a; data_b = 8'ha5;
      repeat (3) @(posedge clk);
      #1;
      compared++;
      if ({win_a, fd_a, top_a, mid_a, bot_a, col_a, row_a} !== '0) begin
         mismatched++;
         $display("FAIL reset_out_a: got win=%0d fd=%0d taps=%0d/%0d/%0d col=%0d row=%0d, want all 0", win_a, fd_a, top_a, mid_a, bot_a, col_a, row_a);
      end
      compared++;
      if ({f1we_a, f1re_a, f2we_a, f2re_a, f1wd_a, f2wd_a} !== '0) begin
         mismatched++;
         $display("FAIL reset_fifo_a: got we1=%0d re1=%0d we2=%0d re2=%0d wd1=%0d wd2=%0d, want all 0", f1we_a, f1re_a, f2we_a, f2re_a, f1wd_a, f2wd_a);
      end
      compared++;
      if ({win_b, fd_b, top_b, mid_b, bot_b, col_b, row_b} !== '0) begin
         mismatched++;
         $display("FAIL reset_out_b: got win=%0d fd=%0d taps=%0d/%0d/%0d col=%0d row=%0d, want all 0", win_b, fd_b, top_b, mid_b, bot_b, col_b, row_b);
      end
      compared++;
      if ({f1we_b, f1re_b, f2we_b, f2re_b, f1wd_b, f2wd_b} !== '0) begin
         mismatched++;
         $display("FAIL reset_fifo_b: got we1=%0d re1=%0d we2=%0d re2=%0d wd1=%0d wd2=%0d, want all 0", f1we_b, f1re_b, f2we_b, f2re_b, f1wd_b, f2wd_b);
      end
      rst_a = 1'b0; rst_b = 1'b0;
      model_reset(0); model_reset(1);
      @(posedge clk); #1;
   endtask

   task automatic test_short_frame();
      logic [7:0] w1[4];
      logic [7:0] w2[4];
      wlog1_a.delete(); wlog2_a.delete();
      for (int i = 0; i < 12; i++) send(0, 8'(i), 0);
      drain(0, "short");
      for (int i = 0; i < 4; i++) begin w1[i] = 8'(i); w2[i] = 8'(i + 4); end
      compared++;
      if (wlog1_a.size() != 4 || wlog2_a.size() != 4) begin
         mismatched++;
         $display("FAIL short_wr_count: got fifo1=%0d fifo2=%0d writes, want 4/4", wlog1_a.size(), wlog2_a.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            compared++;
            if (wlog1_a[i] !== w1[i] || wlog2_a[i] !== w2[i]) begin
               mismatched++;
               $display("FAIL short_wr_data[%0d]: got fifo1=%0d fifo2=%0d, want %0d/%0d", i, wlog1_a[i], wlog2_a[i], w1[i], w2[i]);
            end
         end
      end
      compared++;
      if ({col_a, row_a} !== {2'd3, 2'd2}) begin
         mismatched++;
         $display("FAIL short_pos: got col=%0d row=%0d, want 3/2", col_a, row_a);
      end
      compared++;
      if ({win_a, top_a, mid_a, bot_a} !== {1'b0, 8'd3, 8'd7, 8'd11}) begin
         mismatched++;
         $display("FAIL short_hold: got win=%0d taps=%0d/%0d/%0d, want 0 3/7/11", win_a, top_a, mid_a, bot_a);
      end
   endtask

   task automatic test_gapped();
      for (int i = 0; i < 20; i++) send(1, 8'(i), int'($urandom_range(0, 3)));
      drain(1, "gapped");
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 40; i++) send(1, 8'(i), 0);
      drain(1, "b2b");
      for (int i = 0; i < 12; i++) send(0, 8'(50 + i), 0);
      drain(0, "b2b");
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 9; i++) send(1, 8'(i), 0);
      rst_b = 1'b1;
      exp_b.delete();
      model_reset(1);
      #1;
      compared++;
      if ({win_b, fd_b, top_b, mid_b, bot_b, col_b, row_b} !== '0) begin
         mismatched++;
         $display("FAIL midrst_out: got win=%0d fd=%0d taps=%0d/%0d/%0d col=%0d row=%0d, want all 0", win_b, fd_b, top_b, mid_b, bot_b, col_b, row_b);
      end
      compared++;
      if ({f1we_b, f2we_b, f1re_b, f2re_b, f1wd_b, f2wd_b} !== '0) begin
         mismatched++;
         $display("FAIL midrst_fifo: got we1=%0d we2=%0d re1=%0d re2=%0d wd1=%0d wd2=%0d, want all 0", f1we_b, f2we_b, f1re_b, f2re_b, f1wd_b, f2wd_b);
      end
      @(posedge clk); #1;
      rst_b = 1'b0;
      @(posedge clk); #1;
      for (int i = 0; i < 20; i++) send(1, 8'(200 + i), (i % 3 == 0) ? 1 : 0);
      drain(1, "midrst");
   endtask

   initial begin
      rst_a = 1'b1; rst_b = 1'b1;
      flag_a = 1'b0; flag_b = 1'b0; data_a = '0; data_b = '0;
      f1rd_a = '0; f2rd_a = '0; f1rd_b = '0; f2rd_b = '0;
      fork
         begin
            test_reset();
            test_short_frame();
            test_gapped();
            test_back_to_back();
            test_reset_mid();
            done = 1'b1;
         end
         // Non-FWFT line FIFO models, depth COLS=4, with underflow/overflow checks
         while (!done) begin
            @(posedge clk);
            cyc++;
            if (rst_a) begin
               f1_a.delete(); f2_a.delete();
            end else begin
               if (f1re_a) begin
                  compared++;
                  if (f1_a.size() == 0) begin mismatched++; $display("FAIL fifo1_a_rd: got read of empty FIFO, want count>0"); end
                  else f1rd_a <= f1_a.pop_front();
               end
               if (f2re_a) begin
                  compared++;
                  if (f2_a.size() == 0) begin mismatched++; $display("FAIL fifo2_a_rd: got read of empty FIFO, want count>0"); end
                  else f2rd_a <= f2_a.pop_front();
               end
               if (f1we_a) begin
                  compared++;
                  if (f1_a.size() >= 4) begin mismatched++; $display("FAIL fifo1_a_wr: got write at count %0d, want <4", f1_a.size()); end
                  else begin f1_a.push_back(f1wd_a); wlog1_a.push_back(f1wd_a); end
               end
               if (f2we_a) begin
                  compared++;
                  if (f2_a.size() >= 4) begin mismatched++; $display("FAIL fifo2_a_wr: got write at count %0d, want <4", f2_a.size()); end
                  else begin f2_a.push_back(f2wd_a); wlog2_a.push_back(f2wd_a); end
               end
            end
            if (rst_b) begin
               f1_b.delete(); f2_b.delete();
            end else begin
               if (f1re_b) begin
                  compared++;
                  if (f1_b.size() == 0) begin mismatched++; $display("FAIL fifo1_b_rd: got read of empty FIFO, want count>0"); end
                  else f1rd_b <= f1_b.pop_front();
               end
               if (f2re_b) begin
                  compared++;
                  if (f2_b.size() == 0) begin mismatched++; $display("FAIL fifo2_b_rd: got read of empty FIFO, want count>0"); end
                  else f2rd_b <= f2_b.pop_front();
               end
               if (f1we_b) begin
                  compared++;
                  if (f1_b.size() >= 4) begin mismatched++; $display("FAIL fifo1_b_wr: got write at count %0d, want <4", f1_b.size()); end
                  else f1_b.push_back(f1wd_b);
               end
               if (f2we_b) begin
                  compared++;
                  if (f2_b.size() >= 4) begin mismatched++; $display("FAIL fifo2_b_wr: got write at count %0d, want <4", f2_b.size()); end
                  else f2_b.push_back(f2wd_b);
               end
            end
         end
         // Window monitor: pops the scoreboard on every win_flag
         while (!done) begin
            @(negedge clk);
            if (win_a) begin
               compared++;
               if (exp_a.size() == 0) begin
                  mismatched++;
                  $display("FAIL win_a_extra: got taps %0d/%0d/%0d at cyc %0d, want no window", top_a, mid_a, bot_a, cyc);
               end else begin
                  mon_e = exp_a.pop_front();
                  if ({top_a, mid_a, bot_a, fd_a} !== {mon_e.t, mon_e.m, mon_e.b, mon_e.fd} || 32'(cyc) !== mon_e.cyc) begin
                     mismatched++;
                     $display("FAIL win_a: got %0d/%0d/%0d fd=%0d cyc=%0d, want %0d/%0d/%0d fd=%0d cyc=%0d",
                              top_a, mid_a, bot_a, fd_a, cyc, mon_e.t, mon_e.m, mon_e.b, mon_e.fd, mon_e.cyc);
                  end
               end
            end else if (fd_a) begin
               compared++; mismatched++;
               $display("FAIL fd_a_alone: got frame_done=1 win_flag=0, want frame_done only with win_flag");
            end
            if (win_b) begin
               compared++;
               if (exp_b.size() == 0) begin
                  mismatched++;
                  $display("FAIL win_b_extra: got taps %0d/%0d/%0d at cyc %0d, want no window", top_b, mid_b, bot_b, cyc);
               end else begin
                  mon_e = exp_b.pop_front();
                  if ({top_b, mid_b, bot_b, fd_b} !== {mon_e.t, mon_e.m, mon_e.b, mon_e.fd} || 32'(cyc) !== mon_e.cyc) begin
                     mismatched++;
                     $display("FAIL win_b: got %0d/%0d/%0d fd=%0d cyc=%0d, want %0d/%0d/%0d fd=%0d cyc=%0d",
                              top_b, mid_b, bot_b, fd_b, cyc, mon_e.t, mon_e.m, mon_e.b, mon_e.fd, mon_e.cyc);
                  end
               end
            end else if (fd_b) begin
               compared++; mismatched++;
               $display("FAIL fd_b_alone: got frame_done=1 win_flag=0, want frame_done only with win_flag");
            end
         end
      join
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
